uart_wb_arbiter: RTL and testbench
==================================

UART_WB_ARBITER -- requirements
Module: uart_wb_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the number of cycles to wait for slave ack before aborting (range 1..255).
REQ-002 clk  input  1  single clock, also drives the UART wb_clk; reset is asynchronous and active-high.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 m0_stb, m1_stb  input  1  master request strobes; m0 is CPU, m1 is debug.
REQ-005 m0_we, m1_we  input  1  direction with UART polarity: LOW=write, HIGH=read.
REQ-006 m0_addr, m1_addr  input  2  register address: 0=TX, 1=RX, 2=freq divider.
REQ-007 m0_data_in, m1_data_in  input  8  write data.
REQ-008 m0_data_out, m1_data_out  output  8  read data.
REQ-009 m0_ack, m1_ack  output  1  per-master acknowledge.
REQ-010 s_stb, s_we  output  1  to UART wb_stb/wb_we.
REQ-011 s_addr  output  2  to UART wb_addr.
REQ-012 s_data_out  output  8  to UART wb_data_in.
REQ-013 s_data_in  input  8  from UART wb_data_out.
REQ-014 s_ack  input  1  from UART wb_ack.
REQ-015 timeout_err  output  1  sticky flag, set on any aborted transaction.

Function
REQ-016 Handshake is four-phase on both sides: stb rises, ack rises, stb falls, ack falls; ack held while stb high.
REQ-017 States: IDLE, GRANT, WAIT_ACK_LOW, ABORT.
REQ-018 IDLE: if either m*_stb high, register grant owner and go to GRANT next edge; s_stb stays low in IDLE.
REQ-019 Both requesting in IDLE: grant the master not granted last (round-robin); after reset m0 has priority.
REQ-020 GRANT: s_stb, s_we, s_addr, s_data_out driven from owner's inputs; non-owner signals ignored.
REQ-021 Owner ack = s_ack in GRANT and WAIT_ACK_LOW; non-owner ack = 0 always.
REQ-022 Owner data_out = s_data_in captured on the cycle s_ack is first seen high, held until next grant to that master; non-owner data_out holds.
REQ-023 GRANT: when owner stb drops after s_ack seen, drop s_stb same cycle (combinational gate) and go to WAIT_ACK_LOW.
REQ-024 WAIT_ACK_LOW: on s_ack low, update last_grant to owner, go to IDLE; new grant no earlier than the following edge.
REQ-025 Owner dropping stb before s_ack: s_stb follows low; stay in GRANT until s_ack high or timeout, ack not forwarded if stb low.
REQ-026 8-bit timeout counter clears on entering GRANT, counts each GRANT cycle with s_ack low; reaching TIMEOUT_CYCLES goes to ABORT.
REQ-027 ABORT: s_stb=0, owner ack=1, owner data_out=8'hFF, timeout_err=1; on owner stb low, owner ack=0 next edge, go to IDLE, update last_grant.
REQ-028 Counter saturates, never wraps; timeout_err cleared only by reset.
REQ-029 No combinational path from m*_stb to m*_ack.

Reset
REQ-030 Reset asserted: state=IDLE, last_grant=m1 (so m0 wins first), s_stb=0, s_we=1, s_addr=0, s_data_out=0, m*_ack=0, m*_data_out=0, counter=0, timeout_err=0, all immediately (asynchronous).
REQ-031 Reset mid-transaction aborts without ack; masters must re-issue.

Structure
REQ-032 Shared package holds UART register address constants (TX=0, RX=1, DIV=2), we polarity constants (WRITE=0, READ=1) and the arbiter state encoding.
REQ-033 Single flat module; no sub-module; UART instantiated by the parent.

Verification
REQ-034 m0 writes 0x41 to addr 0, UART acks after 3 cycles -> s_stb, s_data_out=0x41, s_we=0, m0_ack follows s_ack, m1_ack stays 0.
REQ-035 m0 and m1 raise stb on the same edge after reset, twice in a row -> m0 granted first, m1 second, m0 third.
REQ-036 m1 reads addr 1, UART returns 0x5A -> m1_data_out=0x5A held after ack falls; m0_data_out unchanged.
REQ-037 Slave never acks, TIMEOUT_CYCLES=4 -> ABORT after 4 GRANT cycles, m0_ack=1, m0_data_out=0xFF, timeout_err=1 until reset.
REQ-038 Reset asserted while s_stb high -> s_stb, acks and state clear without a clock edge; next request is granted normally.
REQ-039 m1 holds stb during m0 transaction -> m1 not granted until the cycle after s_ack low.

Source files
------------

// File: rtl/uart_wb_arbiter_pkg.sv
// Shared constants for the two-master UART Wishbone arbiter:
// UART register map, wb_we polarity and arbiter state encoding.
package uart_wb_arbiter_pkg;

   localparam logic [1:0] ADDR_TX  = 2'd0;
   localparam logic [1:0] ADDR_RX  = 2'd1;
   localparam logic [1:0] ADDR_DIV = 2'd2;

   // UART polarity: low means write
   localparam logic WE_WRITE = 1'b0;
   localparam logic WE_READ  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_GRANT        = 2'd1,
      ST_WAIT_ACK_LOW = 2'd2,
      ST_ABORT        = 2'd3
   } arb_state_t;

endpackage

// File: rtl/uart_wb_arbiter.sv
// Round-robin arbiter sharing one UART Wishbone slave between the
// CPU (m0) and the debug port (m1), with a slave-ack timeout.
module uart_wb_arbiter
   import uart_wb_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       m0_stb,
   input  logic       m0_we,
   input  logic [1:0] m0_addr,
   input  logic [7:0] m0_data_in,
   output logic [7:0] m0_data_out,
   output logic       m0_ack,
   input  logic       m1_stb,
   input  logic       m1_we,
   input  logic [1:0] m1_addr,
   input  logic [7:0] m1_data_in,
   output logic [7:0] m1_data_out,
   output logic       m1_ack,
   output logic       s_stb,
   output logic       s_we,
   output logic [1:0] s_addr,
   output logic [7:0] s_data_out,
   input  logic [7:0] s_data_in,
   input  logic       s_ack,
   output logic       timeout_err
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   arb_state_t state;
   logic       owner;
   logic       last_grant;
   logic       seen_ack;
   logic       early_drop;
   logic [7:0] tmo_cnt;

   logic       own_stb;
   logic       own_we;
   logic [1:0] own_addr;
   logic [7:0] own_data;
   logic       pick;
   logic       fwd;

   // Select the request lines of the current owner
   always_comb begin
      own_stb  = owner ? m1_stb     : m0_stb;
      own_we   = owner ? m1_we      : m0_we;
      own_addr = owner ? m1_addr    : m0_addr;
      own_data = owner ? m1_data_in : m0_data_in;
   end

   // Next owner: alternate on contention, else whoever asks
   always_comb begin
      if (m0_stb && m1_stb)
         pick = ~last_grant;
      else
         pick = m1_stb;
   end

   // Slave side follows the owner only while granted
   always_comb begin
      s_stb      = 1'b0;
      s_we       = WE_READ;
      s_addr     = ADDR_TX;
      s_data_out = 8'h00;
      if (state == ST_GRANT) begin
         s_stb      = own_stb;
         s_we       = own_we;
         s_addr     = own_addr;
         s_data_out = own_data;
      end
   end

   // Owner ack comes from slave ack or the abort state, never from stb
   always_comb begin
      fwd = 1'b0;
      unique case (state)
         ST_GRANT:        fwd = s_ack & ~early_drop;
         ST_WAIT_ACK_LOW: fwd = s_ack & ~early_drop;
         ST_ABORT:        fwd = 1'b1;
         default:         fwd = 1'b0;
      endcase
      m0_ack = fwd & ~owner;
      m1_ack = fwd & owner;
   end

   // Arbiter FSM, read-data capture and timeout tracking
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         owner       <= 1'b0;
         last_grant  <= 1'b1;
         seen_ack    <= 1'b0;
         early_drop  <= 1'b0;
         tmo_cnt     <= 8'h00;
         timeout_err <= 1'b0;
         m0_data_out <= 8'h00;
         m1_data_out <= 8'h00;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (m0_stb || m1_stb) begin
                  owner      <= pick;
                  seen_ack   <= 1'b0;
                  early_drop <= 1'b0;
                  tmo_cnt    <= 8'h00;
                  state      <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (s_ack && !seen_ack) begin
                  seen_ack <= 1'b1;
                  if (owner)
                     m1_data_out <= s_data_in;
                  else
                     m0_data_out <= s_data_in;
               end
               if ((seen_ack || s_ack) && !own_stb) begin
                  state <= ST_WAIT_ACK_LOW;
               end else if (!seen_ack && !s_ack) begin
                  if (!own_stb)
                     early_drop <= 1'b1;
                  if (tmo_cnt != 8'hFF)
                     tmo_cnt <= tmo_cnt + 8'd1;
                  if (tmo_cnt >= TO_LAST) begin
                     state       <= ST_ABORT;
                     timeout_err <= 1'b1;
                     if (owner)
                        m1_data_out <= 8'hFF;
                     else
                        m0_data_out <= 8'hFF;
                  end
               end
            end
            ST_WAIT_ACK_LOW: begin
               if (!s_ack) begin
                  last_grant <= owner;
                  state      <= ST_IDLE;
               end
            end
            ST_ABORT: begin
               if (!own_stb) begin
                  last_grant <= owner;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_wb_arbiter.sv
// Scoreboard bench for uart_wb_arbiter: masters and a UART slave
// model drive traffic, a monitor checks every owner acknowledge.
module tb_uart_wb_arbiter;
   import uart_wb_arbiter_pkg::*;

   typedef struct {
      int         m;
      logic       we;
      logic [1:0] addr;
      logic [7:0] wd;
      logic [7:0] rd;
      bit         abrt;
      int         lat;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [1:0] mstb;
   logic [1:0] mwe;
   logic [1:0] maddr [2];
   logic [7:0] mdin  [2];
   logic [7:0] m0_data_out, m1_data_out;
   logic       m0_ack, m1_ack;
   logic       s_stb, s_we;
   logic [1:0] s_addr;
   logic [7:0] s_data_out;
   logic [7:0] s_data_in;
   logic       s_ack;
   logic       timeout_err;
   logic [1:0] mack;

   int   n_chk, n_fail;
   int   cyc, stb_cyc, fall_cyc;
   bit   mon_en;
   int   slave_lat, scnt;
   logic [7:0] slave_rd;
   logic [7:0] exp_dout [2];
   exp_t exp_q [$];
   exp_t cur;

   assign mack = {m1_ack, m0_ack};

   uart_wb_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .m0_stb      (mstb[0]),
      .m0_we       (mwe[0]),
      .m0_addr     (maddr[0]),
      .m0_data_in  (mdin[0]),
      .m0_data_out (m0_data_out),
      .m0_ack      (m0_ack),
      .m1_stb      (mstb[1]),
      .m1_we       (mwe[1]),
      .m1_addr     (maddr[1]),
      .m1_data_in  (mdin[1]),
      .m1_data_out (m1_data_out),
      .m1_ack      (m1_ack),
      .s_stb       (s_stb),
      .s_we        (s_we),
      .s_addr      (s_addr),
      .s_data_out  (s_data_out),
      .s_data_in   (s_data_in),
      .s_ack       (s_ack),
      .timeout_err (timeout_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] dout(input int m);
      return (m == 1) ? m1_data_out : m0_data_out;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", nm, act, req);
      end
   endtask

   task automatic push(input int m, input logic we, input logic [1:0] a,
                       input logic [7:0] wd, input logic [7:0] rd,
                       input bit abrt, input int lat);
      exp_t e;
      e.m = m; e.we = we; e.addr = a; e.wd = wd;
      e.rd = rd; e.abrt = abrt; e.lat = lat;
      exp_q.push_back(e);
   endtask

   task automatic wait_ack(input int m, input logic v);
      bit ok;
      ok = 0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if (mack[m] === v) ok = 1;
      end
      if (!ok) begin
         n_chk++;
         n_fail++;
         $display("FAIL ack_wait m%0d: ack never reached %0b", m, v);
      end
   endtask

   task automatic xact(input int m, input logic we, input logic [1:0] a,
                       input logic [7:0] d);
      @(posedge clk);
      #1;
      mwe[m]   = we;
      maddr[m] = a;
      mdin[m]  = d;
      mstb[m]  = 1'b1;
      wait_ack(m, 1'b1);
      @(posedge clk);
      #1;
      mstb[m] = 1'b0;
      wait_ack(m, 1'b0);
   endtask

   // UART slave model: acks after slave_lat strobed cycles (0 = never)
   initial begin
      s_ack = 1'b0;
      s_data_in = 8'h00;
      scnt = 0;
      forever begin
         @(posedge clk);
         #2;
         if (s_stb && !s_ack) begin
            scnt++;
            if (slave_lat != 0 && scnt >= slave_lat) begin
               s_data_in = slave_rd;
               s_ack = 1'b1;
            end
         end else if (!s_stb) begin
            s_ack = 1'b0;
            scnt = 0;
         end
      end
   end

   // Monitor: pops an expectation on every owner ack rise
   initial begin
      logic       p_stb, p_sack;
      logic [1:0] p_ack;
      p_stb = 1'b0; p_sack = 1'b0; p_ack = 2'b00;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (s_stb && !p_stb && fall_cyc >= 0)
               chk("regrant_gap", 32'(cyc - fall_cyc >= 2), 1);
            if (s_stb && !p_stb) stb_cyc = cyc;
            if (p_sack && !s_ack) fall_cyc = cyc;
            for (int m = 0; m < 2; m++) begin
               if (mack[m] && !p_ack[m]) begin
                  if (exp_q.size() == 0) begin
                     n_chk++;
                     n_fail++;
                     $display("FAIL unexpected_ack: m%0d acked, none queued", m);
                  end else begin
                     cur = exp_q.pop_front();
                     chk("ack_owner", m, cur.m);
                     chk("other_ack", mack[1-m], 0);
                     chk("ack_latency", cyc - stb_cyc, cur.lat);
                     if (cur.abrt) begin
                        chk("abort_s_stb", s_stb, 0);
                        chk("abort_err", timeout_err, 1);
                     end else begin
                        chk("s_we", s_we, cur.we);
                        chk("s_addr", s_addr, cur.addr);
                        chk("s_data_out", s_data_out, cur.wd);
                     end
                  end
               end
               if (!mack[m] && p_ack[m]) begin
                  exp_dout[m] = cur.abrt ? 8'hFF : cur.rd;
                  chk("dout_owner", dout(m), exp_dout[m]);
                  chk("dout_other", dout(1-m), exp_dout[1-m]);
               end
            end
         end
         p_stb = s_stb;
         p_sack = s_ack;
         p_ack = mack;
      end
   end

   initial begin
      n_chk = 0; n_fail = 0;
      mon_en = 0; stb_cyc = 0; fall_cyc = -1;
      slave_lat = 3; slave_rd = 8'h00;
      exp_dout[0] = 8'h00; exp_dout[1] = 8'h00;
      mstb = 2'b00; mwe = 2'b11;
      maddr[0] = 2'd0; maddr[1] = 2'd0;
      mdin[0] = 8'h00; mdin[1] = 8'h00;
      reset = 1'b1;
      #3;
      chk("rst_s_stb", s_stb, 0);
      chk("rst_s_we", s_we, 1);
      chk("rst_s_addr", s_addr, 0);
      chk("rst_s_data", s_data_out, 0);
      chk("rst_acks", mack, 0);
      chk("rst_m0_dout", m0_data_out, 0);
      chk("rst_m1_dout", m1_data_out, 0);
      chk("rst_err", timeout_err, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      mon_en = 1;

      // contention twice: m0, m1, then m0 again
      slave_rd = 8'h77;
      push(0, WE_WRITE, ADDR_DIV, 8'h10, 8'h77, 0, 2);
      push(1, WE_WRITE, ADDR_TX, 8'h20, 8'h77, 0, 2);
      fork
         xact(0, WE_WRITE, ADDR_DIV, 8'h10);
         xact(1, WE_WRITE, ADDR_TX, 8'h20);
      join
      push(0, WE_READ, ADDR_RX, 8'h00, 8'h77, 0, 2);
      push(1, WE_READ, ADDR_DIV, 8'h00, 8'h77, 0, 2);
      fork
         xact(0, WE_READ, ADDR_RX, 8'h00);
         xact(1, WE_READ, ADDR_DIV, 8'h00);
      join

      // m0 writes 'A' to TX
      slave_rd = 8'h12;
      push(0, WE_WRITE, ADDR_TX, 8'h41, 8'h12, 0, 2);
      xact(0, WE_WRITE, ADDR_TX, 8'h41);

      // m1 reads RX
      slave_rd = 8'h5A;
      push(1, WE_READ, ADDR_RX, 8'h00, 8'h5A, 0, 2);
      xact(1, WE_READ, ADDR_RX, 8'h00);
      repeat (3) @(negedge clk);
      chk("m1_dout_hold", m1_data_out, 8'h5A);
      chk("m0_dout_hold", m0_data_out, 8'h12);

      // slave never acks
      slave_lat = 0;
      push(0, WE_READ, ADDR_RX, 8'h00, 8'hFF, 1, 4);
      xact(0, WE_READ, ADDR_RX, 8'h00);
      repeat (2) @(negedge clk);
      chk("err_set", timeout_err, 1);
      slave_lat = 3;
      slave_rd = 8'h33;
      push(1, WE_WRITE, ADDR_DIV, 8'h05, 8'h33, 0, 2);
      xact(1, WE_WRITE, ADDR_DIV, 8'h05);
      chk("err_sticky", timeout_err, 1);

      // reset in the middle of an acked transfer
      mon_en = 0;
      slave_rd = 8'h66;
      @(posedge clk);
      #1;
      mwe[0] = WE_WRITE; maddr[0] = ADDR_TX; mdin[0] = 8'hAB;
      mstb[0] = 1'b1;
      wait_ack(0, 1'b1);
      chk("pre_rst_s_stb", s_stb, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_s_stb", s_stb, 0);
      chk("arst_acks", mack, 0);
      chk("arst_s_we", s_we, 1);
      chk("arst_s_data", s_data_out, 0);
      chk("arst_m0_dout", m0_data_out, 0);
      chk("arst_m1_dout", m1_data_out, 0);
      chk("arst_err", timeout_err, 0);
      mstb[0] = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_dout[0] = 8'h00; exp_dout[1] = 8'h00;
      repeat (4) @(negedge clk);
      fall_cyc = -1;
      mon_en = 1;
      slave_rd = 8'h44;
      push(0, WE_WRITE, ADDR_TX, 8'h99, 8'h44, 0, 2);
      xact(0, WE_WRITE, ADDR_TX, 8'h99);
      repeat (2) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
